// File: rtl/fetch_line_reader.sv
// Fetch stage: issues sequential line reads to the instruction BRAM under
// FIFO credit and queues returned lines (data, slot mask, PC) for decode.
module fetch_line_reader #(
    parameter int unsigned           ADDR_W   = 11,
    parameter int unsigned           DEPTH    = 4,
    parameter logic [ADDR_W+2:0]     RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_i,
    input  logic [ADDR_W+2:0]   redirect_pc_i,
    output logic                bram_rd_en,
    output logic [ADDR_W-1:0]   bram_rd_addr,
    input  logic [63:0]         bram_rd_data,
    output logic                ins_valid_o,
    input  logic                ins_ready_i,
    output logic [63:0]         ins_data_o,
    output logic [1:0]          ins_mask_o,
    output logic [ADDR_W+2:0]   ins_pc_o
);

    localparam int unsigned PC_W  = ADDR_W + 3;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fp_q, fp_d;
    logic [1:0]        pm_q, pm_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        inf_mask_q, inf_mask_d;
    logic [ADDR_W-1:0] inf_line_q, inf_line_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rst_done_q, rst_done_d;

    logic [63:0]       mem_data_q [DEPTH];
    logic [1:0]        mem_mask_q [DEPTH];
    logic [ADDR_W-1:0] mem_line_q [DEPTH];

    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;
    logic              unused_pc_bits;

    // Only the line address and the word-select bit of a redirect PC matter.
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Issue/return/pop decisions and next-state for pointers, tracker and FIFO counters.
    // rst_done_q keeps the read port quiet for the first cycle after reset.
    always_comb begin
        occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        issue      = rst_n & rst_done_q & ~redirect_i & (occupancy < (CNT_W + 1)'(DEPTH));
        push       = rst_n & inflight_q & ~redirect_i;
        pop        = ins_valid_o & ins_ready_i;

        fp_d       = fp_q;
        pm_d       = pm_q;
        inflight_d = 1'b0;
        inf_mask_d = inf_mask_q;
        inf_line_d = inf_line_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rst_done_d = 1'b1;

        if (redirect_i) begin
            fp_d    = redirect_pc_i[PC_W-1:3];
            pm_d    = redirect_pc_i[2] ? 2'b10 : 2'b11;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue) begin
                inflight_d = 1'b1;
                inf_line_d = fp_q;
                inf_mask_d = pm_q;
                fp_d       = fp_q + ADDR_W'(1);
                pm_d       = 2'b11;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fp_q       <= RESET_PC[PC_W-1:3];
            pm_q       <= RESET_PC[2] ? 2'b10 : 2'b11;
            inflight_q <= 1'b0;
            inf_mask_q <= 2'b11;
            inf_line_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rst_done_q <= 1'b0;
        end else begin
            fp_q       <= fp_d;
            pm_q       <= pm_d;
            inflight_q <= inflight_d;
            inf_mask_q <= inf_mask_d;
            inf_line_q <= inf_line_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rst_done_q <= rst_done_d;
        end
    end

    // FIFO storage: returned line written at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[tail_q] <= bram_rd_data;
            mem_mask_q[tail_q] <= inf_mask_q;
            mem_line_q[tail_q] <= inf_line_q;
        end
    end

    assign bram_rd_en   = issue;
    assign bram_rd_addr = fp_q;
    assign ins_valid_o  = rst_n & (count_q != '0);
    assign ins_data_o   = mem_data_q[head_q];
    assign ins_mask_o   = mem_mask_q[head_q];
    assign ins_pc_o     = {mem_line_q[head_q], 3'b000};

endmodule

// File: tb/tb_fetch_line_reader.sv
// Bench for fetch_line_reader: BRAM model, scoreboard of the expected
// line/mask stream, directed redirect table and multi-cycle corner sequences.
module tb_fetch_line_reader;

    localparam logic [13:0] TB_RESET_PC = 14'h0000;
    localparam int          TB_DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [13:0] redirect_pc_i;
    logic        bram_rd_en;
    logic [10:0] bram_rd_addr;
    logic [63:0] bram_rd_data = '0;
    logic        ins_valid_o;
    logic        ins_ready_i;
    logic [63:0] ins_data_o;
    logic [1:0]  ins_mask_o;
    logic [13:0] ins_pc_o;

    fetch_line_reader #(
        .ADDR_W   (11),
        .DEPTH    (TB_DEPTH),
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .bram_rd_en    (bram_rd_en),
        .bram_rd_addr  (bram_rd_addr),
        .bram_rd_data  (bram_rd_data),
        .ins_valid_o   (ins_valid_o),
        .ins_ready_i   (ins_ready_i),
        .ins_data_o    (ins_data_o),
        .ins_mask_o    (ins_mask_o),
        .ins_pc_o      (ins_pc_o)
    );

    always #5 clk = ~clk;

    // Distinct contents per line so data and address errors both show.
    function automatic logic [63:0] mem_word(input logic [10:0] a);
        return {a, 21'h1ABCD, 16'h5EED, 5'h00, ~a};
    endfunction

    // One-cycle-latency BRAM read port.
    always @(posedge clk) begin
        if (bram_rd_en) bram_rd_data <= mem_word(bram_rd_addr);
    end

    typedef struct {
        logic [13:0] pc;
        logic [1:0]  mask;
    } exp_t;

    typedef struct {
        logic [13:0] rpc;
        logic [10:0] addr0;
        logic [10:0] addr1;
        logic [13:0] pc0;
        logic [1:0]  mask0;
        logic [13:0] pc1;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          failures = 0;
    int          issue_cnt = 0;
    logic [10:0] exp_issue = '0;
    logic [10:0] gen_line = '0;
    logic [1:0]  gen_mask = 2'b11;
    logic        hold_vld = 1'b0;
    logic [13:0] hold_pc;
    logic [1:0]  hold_mask;
    logic [63:0] hold_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic reseed(input logic [13:0] pc);
        exp_q.delete();
        gen_line  = pc[13:3];
        gen_mask  = pc[2] ? 2'b10 : 2'b11;
        exp_issue = pc[13:3];
        hold_vld  = 1'b0;
    endtask

    // Called once per cycle at the falling edge: compares issue and
    // handshake traffic, then applies this cycle's reset/redirect to the model.
    task automatic monitor();
        exp_t e;
        if (!rst_n || redirect_i) chk("no_issue_rst_or_redirect", bram_rd_en, 1'b0);
        if (!rst_n) chk("valid_in_reset", ins_valid_o, 1'b0);
        if (bram_rd_en) begin
            chk("issue_addr", bram_rd_addr, exp_issue);
            exp_issue = exp_issue + 11'd1;
            issue_cnt++;
        end
        if (hold_vld && rst_n) begin
            chk("hold_valid", ins_valid_o, 1'b1);
            chk("hold_pc_mask", {ins_pc_o, ins_mask_o}, {hold_pc, hold_mask});
            chk("hold_data", ins_data_o, hold_data);
        end
        hold_vld = 1'b0;
        if (rst_n && !redirect_i && ins_valid_o) begin
            if (ins_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty: actual=line %0h required=no line", ins_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", ins_pc_o, e.pc);
                    chk("out_mask", ins_mask_o, e.mask);
                    chk("out_data", ins_data_o, mem_word(e.pc[13:3]));
                end
            end else begin
                hold_vld  = 1'b1;
                hold_pc   = ins_pc_o;
                hold_mask = ins_mask_o;
                hold_data = ins_data_o;
            end
        end
        if (!rst_n) reseed(TB_RESET_PC);
        else if (redirect_i) reseed(redirect_pc_i);
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: {gen_line, 3'b000}, mask: gen_mask});
            gen_line = gen_line + 11'd1;
            gen_mask = 2'b11;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            sample();
            next_cycle();
        end
    endtask

    initial begin
        int gaps;
        vecs[0] = '{rpc: 14'h3FFC, addr0: 11'h7FF, addr1: 11'h000, pc0: 14'h3FF8, mask0: 2'b10, pc1: 14'h0000};
        vecs[1] = '{rpc: 14'h0000, addr0: 11'h000, addr1: 11'h001, pc0: 14'h0000, mask0: 2'b11, pc1: 14'h0008};
        vecs[2] = '{rpc: 14'h1234, addr0: 11'h246, addr1: 11'h247, pc0: 14'h1230, mask0: 2'b10, pc1: 14'h1238};
        vecs[3] = '{rpc: 14'h3FF8, addr0: 11'h7FF, addr1: 11'h000, pc0: 14'h3FF8, mask0: 2'b11, pc1: 14'h0000};
        vecs[4] = '{rpc: 14'h0009, addr0: 11'h001, addr1: 11'h002, pc0: 14'h0008, mask0: 2'b11, pc1: 14'h0010};

        rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; ins_ready_i = 1'b1;
        next_cycle();
        run(3);

        // Reset release: quiet cycle, issue of line 0, valid two cycles later.
        rst_n = 1'b1;
        sample();
        chk("post_rst_rd_en", bram_rd_en, 1'b0);
        chk("post_rst_valid", ins_valid_o, 1'b0);
        next_cycle();
        sample();
        chk("first_issue_en", bram_rd_en, 1'b1);
        chk("first_issue_addr", bram_rd_addr, 11'h000);
        next_cycle();
        sample();
        chk("first_valid_early", ins_valid_o, 1'b0);
        next_cycle();
        sample();
        chk("first_valid", ins_valid_o, 1'b1);
        chk("first_pc", ins_pc_o, 14'h0000);
        chk("first_mask", ins_mask_o, 2'b11);
        next_cycle();
        run(10);

        // Redirects applied mid-stream, while a read is returning.
        for (int i = 0; i < 5; i++) begin
            redirect_i = 1'b1; redirect_pc_i = vecs[i].rpc;
            sample();
            next_cycle();
            redirect_i = 1'b0;
            sample();
            chk("redir_issue0_en", bram_rd_en, 1'b1);
            chk("redir_issue0_addr", bram_rd_addr, vecs[i].addr0);
            next_cycle();
            sample();
            chk("redir_valid_t2", ins_valid_o, 1'b0);
            chk("redir_issue1_addr", bram_rd_addr, vecs[i].addr1);
            next_cycle();
            sample();
            chk("redir_valid_t3", ins_valid_o, 1'b1);
            chk("redir_pc0", ins_pc_o, vecs[i].pc0);
            chk("redir_mask0", ins_mask_o, vecs[i].mask0);
            next_cycle();
            sample();
            chk("redir_pc1", ins_pc_o, vecs[i].pc1);
            chk("redir_mask1", ins_mask_o, 2'b11);
            next_cycle();
            run(3);
        end

        // Backpressure from an empty FIFO: exactly DEPTH reads, then drain with no gap.
        redirect_i = 1'b1; redirect_pc_i = 14'h0400; ins_ready_i = 1'b0;
        sample();
        next_cycle();
        redirect_i = 1'b0;
        issue_cnt = 0;
        run(9);
        sample();
        chk("bp_issue_count", issue_cnt, TB_DEPTH);
        chk("bp_rd_en_stopped", bram_rd_en, 1'b0);
        chk("bp_head_pc", ins_pc_o, 14'h0400);
        next_cycle();
        ins_ready_i = 1'b1;
        gaps = 0;
        repeat (12) begin
            sample();
            if (!ins_valid_o) gaps++;
            next_cycle();
        end
        chk("bp_drain_gaps", gaps, 0);

        // Redirect while the FIFO is full.
        ins_ready_i = 1'b0;
        run(8);
        redirect_i = 1'b1; redirect_pc_i = 14'h2A04; ins_ready_i = 1'b1;
        run(1);
        redirect_i = 1'b0;
        run(10);

        // One-cycle reset mid-stream with the FIFO partially full.
        ins_ready_i = 1'b0;
        run(2);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1; ins_ready_i = 1'b1;
        sample();
        chk("midrst_valid", ins_valid_o, 1'b0);
        chk("midrst_rd_en", bram_rd_en, 1'b0);
        next_cycle();
        sample();
        chk("midrst_restart_addr", bram_rd_addr, TB_RESET_PC[13:3]);
        next_cycle();
        run(8);

        // Random ready and redirects, checked by the scoreboard.
        for (int c = 0; c < 1500; c++) begin
            ins_ready_i = ($urandom_range(0, 9) < 7);
            redirect_i  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc_i = 14'h3FE0 | 14'($urandom_range(0, 31));
            else                           redirect_pc_i = 14'($urandom);
            sample();
            next_cycle();
        end
        redirect_i = 1'b0; ins_ready_i = 1'b1;
        run(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
